pulse_stretcher: RTL and testbench

- Converts single-cycle pulses into held, visible level windows. It is the pulse-to-level counterpart of the button synchronizer, which turns a held key into a one-clock pulse.
- Drives LEDs and other slow indicators from processor event pulses such as instruction step, register write and halt.
- Pulses that arrive while a window is active are queued or retriggered, so no event is silently lost.

---
 rtl/pulse_stretch_pkg.sv | 22 ++
 rtl/pulse_stretcher_if.sv | 32 +++
 rtl/ps_down_counter.sv | 27 ++
 rtl/pulse_stretcher.sv | 153 +++++++++++++++
 tb/tb_pulse_stretcher.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher.
package pulse_stretch_pkg;

  // state | meaning
  // IDLE  | no window active, Lo low, waiting for a pulse
  // HOLD  | Lo high, window counter running
  // GAP   | Lo forced low between windows, queued pulses wait here
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } ps_state_e;

  // The counter only ever holds interval-1, so it needs clog2 of the longer interval.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int longest;
    longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    if (longest <= 1) return 1;
    return $clog2(longest);
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event-side and indicator-side signals of the pulse stretcher.
interface pulse_stretcher_if #(
  parameter int MAX_PENDING = 3
);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          Pi;
  logic          OvfClr;
  logic          Lo;
  logic          Busy;
  logic [PW-1:0] Pending;
  logic          Overflow;

  modport master (
    output Pi,
    output OvfClr,
    input  Lo,
    input  Busy,
    input  Pending,
    input  Overflow
  );

  modport slave (
    input  Pi,
    input  OvfClr,
    output Lo,
    output Busy,
    output Pending,
    output Overflow
  );

endinterface

// File: rtl/ps_down_counter.sv
// Loadable down counter that parks at zero; times both HOLD and GAP intervals.
module ps_down_counter #(
  parameter int WIDTH = 2
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic             Zero
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; otherwise count down and stop at zero.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_count <= '0;
    end else if (Load) begin
      r_count <= LoadVal;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign Zero = (r_count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into HOLD-long Lo windows separated by
// forced-low gaps; pulses arriving mid-window are queued or retrigger the window.
module pulse_stretcher
  import pulse_stretch_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PENDING = 3,
  parameter int RETRIGGER   = 0
) (
  input  logic              Clk,
  input  logic              ResetN,
  pulse_stretcher_if.slave  bus
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("pulse_stretcher: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("pulse_stretcher: GAP_CYCLES must be >= 1");
  end
  if (MAX_PENDING < 1) begin : g_bad_pend
    $error("pulse_stretcher: MAX_PENDING must be >= 1");
  end
  if (RETRIGGER != 0 && RETRIGGER != 1) begin : g_bad_retrig
    $error("pulse_stretcher: RETRIGGER must be 0 or 1");
  end

  ps_state_e     r_state;
  logic          r_lo;
  logic          r_busy;
  logic          r_overflow;
  logic [PW-1:0] r_pending;

  logic          w_zero;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_retrig;
  logic          w_hold_done;
  logic          w_gap_done;
  logic          w_eff_pending;
  logic          w_inc;
  logic          w_dec;
  logic          w_drop;
  logic          w_start;

  // A retrigger on the last HOLD cycle wins over the HOLD->GAP transition.
  assign w_retrig    = (r_state == HOLD) && bus.Pi && (RETRIGGER != 0);
  assign w_hold_done = (r_state == HOLD) && w_zero && !w_retrig;
  assign w_gap_done  = (r_state == GAP) && w_zero;

  // Counting this cycle's pulse lets a pulse on the last GAP cycle start the
  // next window directly instead of passing through the queue.
  assign w_eff_pending = (r_pending != '0) || bus.Pi;

  assign w_inc  = bus.Pi && (((r_state == HOLD) && (RETRIGGER == 0)) || (r_state == GAP));
  assign w_dec  = w_gap_done && w_eff_pending;
  assign w_drop = w_inc && !w_dec && (r_pending == PEND_MAX);

  assign w_start    = ((r_state == IDLE) && bus.Pi) || w_retrig || w_dec;
  assign w_load     = w_start || w_hold_done;
  assign w_load_val = w_hold_done ? GAP_LOAD : HOLD_LOAD;

  ps_down_counter #(
    .WIDTH (CW)
  ) u_interval_cnt (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .Load    (w_load),
    .LoadVal (w_load_val),
    .Zero    (w_zero)
  );

  // Window sequencing with Lo/Busy registered alongside the state they reflect.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_state <= IDLE;
      r_lo    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Pi) begin
            r_state <= HOLD;
            r_lo    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        HOLD: begin
          if (w_hold_done) begin
            r_state <= GAP;
            r_lo    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        GAP: begin
          if (w_gap_done) begin
            if (w_eff_pending) begin
              r_state <= HOLD;
              r_lo    <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_lo    <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_lo    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pending queue depth: saturates at MAX_PENDING, simultaneous inc/dec cancel.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_pending <= '0;
    end else if (w_inc && !w_dec) begin
      if (r_pending != PEND_MAX) begin
        r_pending <= r_pending + PW'(1);
      end
    end else if (w_dec && !w_inc) begin
      r_pending <= r_pending - PW'(1);
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.OvfClr) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.Lo       = r_lo;
  assign bus.Busy     = r_busy;
  assign bus.Pending  = r_pending;
  assign bus.Overflow = r_overflow;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench: two stretchers (queue mode and retrigger mode) share one
// stimulus stream; a window-interval model predicts each cycle's outputs.
module tb_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int MP = 3;

  logic clk = 1'b0;
  logic rstn;

  pulse_stretcher_if #(.MAX_PENDING(MP)) bus0 ();
  pulse_stretcher_if #(.MAX_PENDING(MP)) bus1 ();

  pulse_stretcher #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .MAX_PENDING (MP),
    .RETRIGGER   (0)
  ) u_dut_queue (
    .Clk    (clk),
    .ResetN (rstn),
    .bus    (bus0)
  );

  pulse_stretcher #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .MAX_PENDING (MP),
    .RETRIGGER   (1)
  ) u_dut_retrig (
    .Clk    (clk),
    .ResetN (rstn),
    .bus    (bus1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lo;
    bit busy;
    int pend;
    bit ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mcyc     = 0;

  // Model state per instance: current window as absolute cycle intervals.
  int hs[2];
  int he[2];
  int ge[2];
  int pend[2];
  bit ovf[2];

  logic [19:0] d_pi[6];
  logic [19:0] d_rst[6];
  logic [19:0] d_clr[6];

  task automatic model_step(input int m, input int t, input bit rst_n, input bit pi,
                            input bit clr, output exp_t e);
    bit drop;
    bit in_hold;
    bit in_gap;
    int eff;
    drop = 1'b0;
    if (!rst_n) begin
      hs[m] = -100; he[m] = -100; ge[m] = -100;
      pend[m] = 0;  ovf[m] = 1'b0;
    end else begin
      in_hold = (t >= hs[m]) && (t <= he[m]);
      in_gap  = (t > he[m]) && (t <= ge[m]);
      if (!in_hold && !in_gap) begin
        if (pi) begin
          hs[m] = t + 1; he[m] = t + H; ge[m] = t + H + G;
        end
      end else if (in_hold) begin
        if (pi) begin
          if (m == 1) begin
            he[m] = t + H; ge[m] = t + H + G;
          end else if (pend[m] == MP) begin
            drop = 1'b1;
          end else begin
            pend[m]++;
          end
        end
      end else begin
        if (t == ge[m]) begin
          eff = pend[m] + (pi ? 1 : 0);
          if (eff > 0) begin
            hs[m] = t + 1; he[m] = t + H; ge[m] = t + H + G;
            pend[m] = eff - 1;
          end
        end else if (pi) begin
          if (pend[m] == MP) drop = 1'b1;
          else pend[m]++;
        end
      end
      if (drop) ovf[m] = 1'b1;
      else if (clr) ovf[m] = 1'b0;
    end
    e.lo   = (t + 1 >= hs[m]) && (t + 1 <= he[m]);
    e.busy = (t + 1 >= hs[m]) && (t + 1 <= ge[m]);
    e.pend = pend[m];
    e.ovf  = ovf[m];
  endtask

  task automatic drive(input bit rst_n, input bit pi, input bit clr);
    exp_t e0;
    exp_t e1;
    rstn        = rst_n;
    bus0.Pi     = pi;
    bus1.Pi     = pi;
    bus0.OvfClr = clr;
    bus1.OvfClr = clr;
    model_step(0, cyc, rst_n, pi, clr, e0);
    model_step(1, cyc, rst_n, pi, clr, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, mcyc, act, exp);
    end
  endtask

  // Monitor: every cycle the DUTs present outputs; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL q0_empty cycle=%0d actual=0 expected=1", mcyc);
      end else begin
        e = q0.pop_front();
        cmp("queue_lo",       {31'b0, bus0.Lo},       {31'b0, e.lo});
        cmp("queue_busy",     {31'b0, bus0.Busy},     {31'b0, e.busy});
        cmp("queue_pending",  {30'b0, bus0.Pending},  e.pend);
        cmp("queue_overflow", {31'b0, bus0.Overflow}, {31'b0, e.ovf});
      end
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL q1_empty cycle=%0d actual=0 expected=1", mcyc);
      end else begin
        e = q1.pop_front();
        cmp("retrig_lo",       {31'b0, bus1.Lo},       {31'b0, e.lo});
        cmp("retrig_busy",     {31'b0, bus1.Busy},     {31'b0, e.busy});
        cmp("retrig_pending",  {30'b0, bus1.Pending},  e.pend);
        cmp("retrig_overflow", {31'b0, bus1.Overflow}, {31'b0, e.ovf});
      end
      mcyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", mcyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prob;
    bit pi;
    bit clr;
    bit rst_n;
    // Directed windows; bit c = cycle c after the first pulse.
    d_pi[0] = 20'h00001; d_rst[0] = 20'h0; d_clr[0] = 20'h0;
    d_pi[1] = 20'h00005; d_rst[1] = 20'h0; d_clr[1] = 20'h0;
    d_pi[2] = 20'h0001F; d_rst[2] = 20'h0; d_clr[2] = 20'h00040;
    d_pi[3] = 20'h00009; d_rst[3] = 20'h0; d_clr[3] = 20'h0;
    d_pi[4] = 20'h00041; d_rst[4] = 20'h0; d_clr[4] = 20'h0;
    d_pi[5] = 20'h00105; d_rst[5] = 20'h4; d_clr[5] = 20'h0;

    for (int i = 0; i < 6; i++) begin
      hs[i % 2] = -100;
    end

    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);

    for (int s = 0; s < 6; s++) begin
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 20; c++) begin
        drive(!d_rst[s][c], d_pi[s][c], d_clr[s][c]);
      end
    end

    for (int i = 0; i < 3000; i++) begin
      case ((i / 200) % 3)
        0:       prob = 15;
        1:       prob = 45;
        default: prob = 85;
      endcase
      pi    = ($urandom_range(0, 99) < prob);
      clr   = ($urandom_range(0, 99) < 4);
      rst_n = !($urandom_range(0, 999) < 3);
      drive(rst_n, pi, clr);
    end

    cmp("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
